// File: rtl/Q.sv
// Q: maps a 4-bit nibble x to a 2-bit code Qx. The code is the population count of x modulo 4.
// Ports:
//   x  - input nibble
//   Qx - 2-bit code
module Q (
  input  logic [3:0] x,
  output logic [1:0] Qx
);

  assign Qx = {1'b0, x[0]} + {1'b0, x[1]} + {1'b0, x[2]} + {1'b0, x[3]};

endmodule

// File: rtl/q_sequencer.sv
// q_sequencer: accepts a word of NIBBLES nibbles and runs each nibble through a single shared
// Q instance, one nibble per clock. The packed 2-bit codes are returned as one result word.
// Handshake: in_valid/in_ready on the input side and out_valid/out_ready on the output side.
// Only one word is in flight at a time.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   in_valid, in_ready  - input handshake (in_ready is high only while idle)
//   in_data             - input word, 4*NIBBLES bits
//   out_valid, out_ready- output handshake (out_valid is high only while a result is held)
//   out_data            - result word, 2*NIBBLES bits; slice i is Q(nibble i)
//   word_count          - 16-bit count of completed output handshakes, wrapping
//                         (only present when Q_SEQ_COUNT_EN is defined)
module q_sequencer #(
  parameter int unsigned NIBBLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*NIBBLES-1:0]   out_data
`ifdef Q_SEQ_COUNT_EN
  ,
  output logic [15:0]            word_count
`endif
);

  localparam int unsigned IdxW = $clog2(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e               state_q;
  logic [IdxW-1:0]      idx_q;
  logic [4*NIBBLES-1:0] word_q;
  logic [2*NIBBLES-1:0] out_data_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [3:0]           q_x;
  logic [1:0]           q_qx;

  // Selects the current nibble from the registered word, never from the live input.
  assign q_x = word_q[{idx_q, 2'b00} +: 4];

  Q u_q (
    .x  (q_x),
    .Qx (q_qx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      word_q      <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            word_q     <= in_data;
            idx_q      <= '0;
            out_data_q <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          out_data_q[{idx_q, 1'b0} +: 2] <= q_qx;
          if (idx_q == LastIdx) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          // Always passes through idle, even if a new word is already waiting.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          idx_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef Q_SEQ_COUNT_EN
  logic [15:0] word_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_count_q <= '0;
    end else if (state_q == StDone && out_ready) begin
      word_count_q <= word_count_q + 16'd1;
    end
  end

  assign word_count = word_count_q;
`endif

endmodule

// File: doc/q_sequencer.md
Q_SEQUENCER -- requirements
Module: q_sequencer

Interface
REQ-001 SHALL have parameter NIBBLES, default 8, meaning the number of 4-bit nibbles per input word (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the input word is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-006 SHALL have port in_data, input, 4*NIBBLES bits: the word to transform.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data holds a complete result.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 SHALL have port out_data, output, 2*NIBBLES bits: the transformed word.

Function
REQ-010 SHALL contain exactly one instance of existing module Q (x[3:0] -> Qx[1:0]), time-shared across all nibbles.
REQ-011 SHALL implement the states IDLE, RUN and DONE, encoded as 2 bits.
REQ-012 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-013 SHALL, on an edge in IDLE with in_valid=1, register in_data, clear nibble index idx to 0, clear out_data and go to RUN; with in_valid=0 it SHALL stay in IDLE.
REQ-014 SHALL, in RUN, drive Q.x = in_data[4*idx+3 : 4*idx] on the registered copy.
REQ-015 SHALL, on each RUN edge, write Q.Qx into out_data[2*idx+1 : 2*idx] and increment idx.
REQ-016 SHALL, on the RUN edge where idx = NIBBLES-1, write the last slice and go to DONE.
REQ-017 SHALL assert out_valid exactly NIBBLES edges after the accept edge: no bubbles, no early assertion.
REQ-018 SHALL hold out_data stable in DONE until the edge where out_ready=1, then go to IDLE.
REQ-019 SHALL ignore in_valid and in_data while in RUN or DONE; there is no queuing and no overwrite of the registered word.
REQ-020 SHALL return to IDLE (not DONE) when out_ready=1 in DONE and in_valid=1 on the same edge; the new word is accepted on the following edge.
REQ-021 SHALL ignore out_ready outside DONE.
REQ-022 SHALL size idx to ceil(log2(NIBBLES)) bits, with no wrap past NIBBLES-1.
REQ-023 SHALL never let out_data contain slices from two different input words.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set state=IDLE, idx=0, out_data=0 and the registered word to 0.
REQ-025 SHALL drive in_ready=1 and out_valid=0 on the cycle after a reset edge.
REQ-026 SHALL let rst override all other inputs, including in RUN or DONE mid-operation; a partial result is discarded and no out_valid pulse occurs.

Configuration
REQ-027 SHALL, when macro Q_SEQ_COUNT_EN is defined, add output port word_count (16 bits).
REQ-028 SHALL, with Q_SEQ_COUNT_EN defined, increment word_count on each out handshake (DONE and out_ready=1), reset it to 0, and wrap it from 16'hFFFF to 16'h0000.
REQ-029 SHALL, without Q_SEQ_COUNT_EN, omit the word_count port and its logic entirely; all other behaviour is identical.

Verification
REQ-030 SHALL cover: reset, then in_data=32'h76543210 accepted at edge E -> out_valid rises at edge E+8 with out_data={Q(7),Q(6),...,Q(0)} from the Q golden table.
REQ-031 SHALL cover: all 16 nibble values via words 32'hFEDCBA98 and 32'h76543210 -> every 2-bit slice matches the golden table.
REQ-032 SHALL cover: out_ready held at 0 for 5 cycles in DONE -> out_valid and out_data stay stable; in_valid pulses during RUN/DONE are ignored and in_ready stays 0.
REQ-033 SHALL cover: rst=1 at the 4th RUN edge -> next cycle state IDLE, out_valid=0, out_data=0, in_ready=1; a subsequent word produces a correct result.
REQ-034 SHALL cover: out_ready=1 and in_valid=1 on the same DONE edge -> IDLE for one cycle, the new word is accepted on the next edge, and back-to-back results are correct.
REQ-035 SHALL cover, with Q_SEQ_COUNT_EN defined: 3 completed transfers -> word_count=3; counter preloaded to 16'hFFFF via transfers or force, one more transfer -> word_count=0.
